// File: rtl/axis_pr_freeze_gate_pkg.sv
// Shared types for the PR freeze gate: per-channel TX state encoding and
// the default tuser bit used to poison a forced terminating beat.
package pr_freeze_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    TERM,
    FROZEN
  } t_frz_state;

  localparam int unsigned POISON_BIT_DEFAULT = 0;

endpackage

// File: rtl/axis_pr_freeze_gate_if.sv
// Bundled multi-channel AXI-S link; each channel owns one bit of the
// handshake vectors and one TDATA/TUSER-wide slice of the payload.
interface axis_pr_freeze_gate_if #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) ();

  logic [NUM_CH-1:0]             tvalid;
  logic [NUM_CH-1:0]             tready;
  logic [NUM_CH-1:0]             tlast;
  logic [NUM_CH*TDATA_WIDTH-1:0] tdata;
  logic [NUM_CH*TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tuser, output tready);

endinterface

// File: rtl/axis_pr_freeze_gate_ch.sv
// One channel of the freeze gate: TX drain-to-boundary FSM with idle
// timeout and poisoned termination, plus RX packet-aligned drop control.
module axis_pr_freeze_gate_ch
  import pr_freeze_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH   = 512,
  parameter int unsigned TUSER_WIDTH   = 10,
  parameter int unsigned POISON_BIT    = POISON_BIT_DEFAULT,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   softreset,
  input  logic                   freeze_req,

  input  logic                   tx_s_tvalid,
  output logic                   tx_s_tready,
  input  logic                   tx_s_tlast,
  input  logic [TDATA_WIDTH-1:0] tx_s_tdata,
  input  logic [TUSER_WIDTH-1:0] tx_s_tuser,

  output logic                   tx_m_tvalid,
  input  logic                   tx_m_tready,
  output logic                   tx_m_tlast,
  output logic [TDATA_WIDTH-1:0] tx_m_tdata,
  output logic [TUSER_WIDTH-1:0] tx_m_tuser,

  input  logic                   rx_s_tvalid,
  output logic                   rx_s_tready,
  input  logic                   rx_s_tlast,
  input  logic [TDATA_WIDTH-1:0] rx_s_tdata,
  input  logic [TUSER_WIDTH-1:0] rx_s_tuser,

  output logic                   rx_m_tvalid,
  input  logic                   rx_m_tready,
  output logic                   rx_m_tlast,
  output logic [TDATA_WIDTH-1:0] rx_m_tdata,
  output logic [TUSER_WIDTH-1:0] rx_m_tuser,

  output t_frz_state             state,
  output logic                   drop,
  output logic                   term_done
);

  logic             mid_pkt;
  logic             mid_pkt_next;
  logic             tx_accept;
  logic [CNT_W-1:0] idle_cnt;
  logic             rx_mid_pkt;
  logic             rx_mid_next;
  logic             rx_accept;

  always_comb begin
    tx_m_tvalid = 1'b0;
    tx_m_tlast  = tx_s_tlast;
    tx_m_tdata  = tx_s_tdata;
    tx_m_tuser  = tx_s_tuser;
    tx_s_tready = 1'b0;
    case (state)
      RUN, DRAIN: begin
        tx_m_tvalid = tx_s_tvalid;
        tx_s_tready = tx_m_tready;
      end
      TERM: begin
        tx_m_tvalid             = 1'b1;
        tx_m_tlast              = 1'b1;
        tx_m_tdata              = '0;
        tx_m_tuser              = '0;
        tx_m_tuser[POISON_BIT]  = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_accept    = tx_s_tvalid & tx_s_tready;
  assign mid_pkt_next = tx_accept ? ~tx_s_tlast : mid_pkt;
  assign term_done    = (state == TERM) & tx_m_tready;

  // DRAIN priority: abort, then boundary tlast, then accept, then timeout.
  always_ff @(posedge clk) begin
    if (softreset) begin
      state    <= RUN;
      mid_pkt  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          mid_pkt  <= mid_pkt_next;
          idle_cnt <= '0;
          if (freeze_req) state <= mid_pkt_next ? DRAIN : FROZEN;
        end
        DRAIN: begin
          mid_pkt <= mid_pkt_next;
          if (!freeze_req) begin
            state <= RUN;
          end else if (tx_accept && tx_s_tlast) begin
            state <= FROZEN;
          end else if (tx_accept) begin
            idle_cnt <= '0;
          end else if (idle_cnt == CNT_W'(DRAIN_TIMEOUT - 1)) begin
            state <= TERM;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        TERM: begin
          mid_pkt <= 1'b0;
          if (tx_m_tready) state <= FROZEN;
        end
        default: begin
          mid_pkt <= 1'b0;
          if (!freeze_req) state <= RUN;
        end
      endcase
    end
  end

  assign rx_m_tvalid = rx_s_tvalid & ~drop;
  assign rx_m_tlast  = rx_s_tlast;
  assign rx_m_tdata  = rx_s_tdata;
  assign rx_m_tuser  = rx_s_tuser;
  assign rx_s_tready = drop | rx_m_tready;

  assign rx_accept   = rx_s_tvalid & rx_s_tready;
  assign rx_mid_next = rx_accept ? ~rx_s_tlast : rx_mid_pkt;

  // Drop only changes at an upstream packet boundary so packets stay whole.
  always_ff @(posedge clk) begin
    if (softreset) begin
      rx_mid_pkt <= 1'b0;
      drop       <= 1'b0;
    end else begin
      rx_mid_pkt <= rx_mid_next;
      if (!rx_mid_next) drop <= freeze_req;
    end
  end

endmodule

// File: rtl/axis_pr_freeze_gate.sv
// Multi-channel packet-aware PR isolation gate: per-channel gating slices,
// global freeze acknowledge and sticky per-channel timeout flags.
module axis_pr_freeze_gate
  import pr_freeze_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned TDATA_WIDTH   = 512,
  parameter int unsigned TUSER_WIDTH   = 10,
  parameter int unsigned POISON_BIT    = POISON_BIT_DEFAULT,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  softreset,
  input  logic                  freeze_req,
  output logic                  freeze_ack,
  output logic [NUM_CH-1:0]     timeout_flag,
  axis_pr_freeze_gate_if.slave  tx_s,
  axis_pr_freeze_gate_if.master tx_m,
  axis_pr_freeze_gate_if.slave  rx_s,
  axis_pr_freeze_gate_if.master rx_m
);

  t_frz_state        state [NUM_CH];
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] term_done;
  logic [NUM_CH-1:0] ch_quiet;
  logic              freeze_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_pr_freeze_gate_ch #(
      .TDATA_WIDTH   (TDATA_WIDTH),
      .TUSER_WIDTH   (TUSER_WIDTH),
      .POISON_BIT    (POISON_BIT),
      .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk         (clk),
      .softreset   (softreset),
      .freeze_req  (freeze_req),
      .tx_s_tvalid (tx_s.tvalid[i]),
      .tx_s_tready (tx_s.tready[i]),
      .tx_s_tlast  (tx_s.tlast[i]),
      .tx_s_tdata  (tx_s.tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
      .tx_s_tuser  (tx_s.tuser[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .tx_m_tvalid (tx_m.tvalid[i]),
      .tx_m_tready (tx_m.tready[i]),
      .tx_m_tlast  (tx_m.tlast[i]),
      .tx_m_tdata  (tx_m.tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
      .tx_m_tuser  (tx_m.tuser[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .rx_s_tvalid (rx_s.tvalid[i]),
      .rx_s_tready (rx_s.tready[i]),
      .rx_s_tlast  (rx_s.tlast[i]),
      .rx_s_tdata  (rx_s.tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
      .rx_s_tuser  (rx_s.tuser[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .rx_m_tvalid (rx_m.tvalid[i]),
      .rx_m_tready (rx_m.tready[i]),
      .rx_m_tlast  (rx_m.tlast[i]),
      .rx_m_tdata  (rx_m.tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
      .rx_m_tuser  (rx_m.tuser[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .state       (state[i]),
      .drop        (drop[i]),
      .term_done   (term_done[i])
    );

    assign ch_quiet[i] = (state[i] == FROZEN) & drop[i];
  end

  // A new freeze request starts a fresh flag epoch; a completing forced
  // termination in the same cycle still records.
  always_ff @(posedge clk) begin
    if (softreset) begin
      freeze_q     <= 1'b0;
      freeze_ack   <= 1'b0;
      timeout_flag <= '0;
    end else begin
      freeze_q     <= freeze_req;
      freeze_ack   <= &ch_quiet;
      timeout_flag <= ((freeze_req && !freeze_q) ? '0 : timeout_flag) | term_done;
    end
  end

endmodule

// File: tb/tb_axis_pr_freeze_gate.sv
// Directed bench for axis_pr_freeze_gate: channel-0 TX/RX scoreboards plus
// cycle-exact checks of freeze, drain, timeout, drop and reset behaviour.
module tb_axis_pr_freeze_gate;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned UW  = 4;
  localparam int unsigned TO  = 8;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  logic           clk = 1'b0;
  logic           softreset;
  logic           freeze_req;
  logic           freeze_ack;
  logic [NCH-1:0] timeout_flag;
  int             checks = 0;
  int             errors = 0;
  beat_t          txq[$];
  beat_t          rxq[$];

  axis_pr_freeze_gate_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) tx_s ();
  axis_pr_freeze_gate_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) tx_m ();
  axis_pr_freeze_gate_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) rx_s ();
  axis_pr_freeze_gate_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) rx_m ();

  axis_pr_freeze_gate #(
    .NUM_CH        (NCH),
    .TDATA_WIDTH   (DW),
    .TUSER_WIDTH   (UW),
    .POISON_BIT    (0),
    .DRAIN_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .softreset    (softreset),
    .freeze_req   (freeze_req),
    .freeze_ack   (freeze_ack),
    .timeout_flag (timeout_flag),
    .tx_s         (tx_s),
    .tx_m         (tx_m),
    .rx_s         (rx_s),
    .rx_m         (rx_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic tx_drive(input logic v, input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    beat_t b;
    tx_s.tvalid[0]     = v;
    tx_s.tdata[DW-1:0] = d;
    tx_s.tuser[UW-1:0] = u;
    tx_s.tlast[0]      = l;
    if (v) begin
      b.last = l; b.user = u; b.data = d;
      txq.push_back(b);
    end
  endtask

  task automatic rx_drive(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l, input logic deliver);
    beat_t b;
    rx_s.tvalid[0]     = 1'b1;
    rx_s.tdata[DW-1:0] = d;
    rx_s.tuser[UW-1:0] = u;
    rx_s.tlast[0]      = l;
    if (deliver) begin
      b.last = l; b.user = u; b.data = d;
      rxq.push_back(b);
    end
  endtask

  // Scoreboard side: every channel-0 handshake must match the next expected beat.
  always @(negedge clk) begin
    if (softreset === 1'b0) begin
      if (tx_m.tvalid[0] === 1'b1 && tx_m.tready[0] === 1'b1) begin
        chk("tx_beat_expected", 64'(txq.size() != 0), 64'd1);
        if (txq.size() != 0)
          chk("tx_beat", 64'({tx_m.tlast[0], tx_m.tuser[UW-1:0], tx_m.tdata[DW-1:0]}),
              64'(txq.pop_front()));
      end
      if (rx_m.tvalid[0] === 1'b1 && rx_m.tready[0] === 1'b1) begin
        chk("rx_beat_expected", 64'(rxq.size() != 0), 64'd1);
        if (rxq.size() != 0)
          chk("rx_beat", 64'({rx_m.tlast[0], rx_m.tuser[UW-1:0], rx_m.tdata[DW-1:0]}),
              64'(rxq.pop_front()));
      end
    end
  end

  initial begin
    softreset   = 1'b1;
    freeze_req  = 1'b0;
    tx_s.tvalid = '0; tx_s.tlast = '0; tx_s.tdata = '0; tx_s.tuser = '0;
    rx_s.tvalid = '0; rx_s.tlast = '0; rx_s.tdata = '0; rx_s.tuser = '0;
    tx_m.tready = '1;
    rx_m.tready = '1;
    repeat (3) nxt();
    mid();
    chk("rst_ack", 64'(freeze_ack), 64'd0);
    chk("rst_flag", 64'(timeout_flag), 64'd0);
    chk("rst_tx_tvalid", 64'(tx_m.tvalid), 64'd0);
    chk("rst_rx_tvalid", 64'(rx_m.tvalid), 64'd0);
    chk("rst_tx_ready", 64'(tx_s.tready), 64'd3);
    nxt();
    softreset = 1'b0;
    repeat (2) nxt();

    // Idle freeze
    freeze_req = 1'b1;
    mid();
    chk("idle_run_ready", 64'(tx_s.tready), 64'd3);
    nxt();
    tx_s.tvalid = '1;
    mid();
    chk("idle_frozen_ready", 64'(tx_s.tready), 64'd0);
    chk("idle_frozen_tvalid", 64'(tx_m.tvalid), 64'd0);
    chk("idle_ack_early", 64'(freeze_ack), 64'd0);
    nxt();
    tx_s.tvalid = '0;
    rx_m.tready = '0;
    rx_s.tvalid = '1;
    rx_s.tlast  = '1;
    mid();
    chk("idle_ack", 64'(freeze_ack), 64'd1);
    chk("idle_rx_gated", 64'(rx_m.tvalid), 64'd0);
    chk("idle_rx_sink", 64'(rx_s.tready), 64'd3);
    nxt();
    rx_s.tvalid = '0;
    rx_s.tlast  = '0;
    rx_m.tready = '1;
    freeze_req  = 1'b0;
    nxt();
    mid();
    chk("unfreeze_ready", 64'(tx_s.tready), 64'd3);
    chk("unfreeze_ack_hold", 64'(freeze_ack), 64'd1);
    nxt();
    mid();
    chk("unfreeze_ack_clr", 64'(freeze_ack), 64'd0);
    nxt();

    // Drain to boundary
    tx_drive(1'b1, 32'h0000_00A1, 4'h2, 1'b0);
    nxt();
    tx_drive(1'b1, 32'h0000_00A2, 4'h3, 1'b0);
    freeze_req = 1'b1;
    nxt();
    tx_drive(1'b1, 32'h0000_00A3, 4'h4, 1'b0);
    mid();
    chk("drain_pass", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    nxt();
    tx_drive(1'b1, 32'h0000_00A4, 4'h5, 1'b1);
    mid();
    chk("drain_last_pass", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    mid();
    chk("drain_frozen", 64'(tx_s.tready), 64'd0);
    chk("drain_no_flag", 64'(timeout_flag), 64'd0);
    nxt();
    mid();
    chk("drain_ack", 64'(freeze_ack), 64'd1);
    freeze_req = 1'b0;
    nxt();
    nxt();

    // Timeout with stalled termination beat
    tx_drive(1'b1, 32'h0000_00B1, 4'h6, 1'b0);
    freeze_req = 1'b1;
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    tx_m.tready[0] = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      mid();
      chk("term_early", 64'(tx_m.tvalid[0]), 64'd0);
      nxt();
    end
    mid();
    chk("term_tvalid", 64'(tx_m.tvalid[0]), 64'd1);
    chk("term_tlast", 64'(tx_m.tlast[0]), 64'd1);
    chk("term_tdata", 64'(tx_m.tdata[DW-1:0]), 64'd0);
    chk("term_tuser", 64'(tx_m.tuser[UW-1:0]), 64'd1);
    chk("term_src_ready", 64'(tx_s.tready[0]), 64'd0);
    nxt();
    mid();
    chk("term_hold1", 64'(tx_m.tvalid[0]), 64'd1);
    nxt();
    mid();
    chk("term_hold2", 64'(tx_m.tvalid[0]), 64'd1);
    chk("term_flag_pending", 64'(timeout_flag), 64'd0);
    nxt();
    tx_m.tready[0] = 1'b1;
    begin
      beat_t b;
      b.last = 1'b1; b.user = 4'h1; b.data = '0;
      txq.push_back(b);
    end
    nxt();
    mid();
    chk("term_frozen", 64'(tx_m.tvalid[0]), 64'd0);
    chk("term_flag", 64'(timeout_flag), 64'd1);
    freeze_req = 1'b0;
    nxt();
    mid();
    chk("flag_sticky", 64'(timeout_flag), 64'd1);
    nxt();

    // RX drop alignment
    rx_drive(32'h0000_0C11, 4'h1, 1'b0, 1'b1);
    nxt();
    rx_drive(32'h0000_0C12, 4'h2, 1'b0, 1'b1);
    freeze_req = 1'b1;
    mid();
    chk("rx_mid_pass", 64'(rx_m.tvalid[0]), 64'd1);
    nxt();
    rx_drive(32'h0000_0C13, 4'h3, 1'b1, 1'b1);
    mid();
    chk("rx_tail_pass", 64'(rx_m.tvalid[0]), 64'd1);
    chk("flag_clr_on_rise", 64'(timeout_flag), 64'd0);
    nxt();
    for (int k = 0; k < 3; k++) begin
      rx_drive(32'h0000_0C20 + DW'(k), 4'h4, k == 2, 1'b0);
      mid();
      chk("rx_drop_p2", 64'(rx_m.tvalid[0]), 64'd0);
      chk("rx_drop_sink", 64'(rx_s.tready[0]), 64'd1);
      nxt();
    end
    rx_drive(32'h0000_0C31, 4'h5, 1'b0, 1'b0);
    nxt();
    rx_drive(32'h0000_0C32, 4'h5, 1'b0, 1'b0);
    freeze_req = 1'b0;
    mid();
    chk("rx_drop_after_unfreeze", 64'(rx_m.tvalid[0]), 64'd0);
    nxt();
    rx_drive(32'h0000_0C33, 4'h5, 1'b1, 1'b0);
    nxt();
    for (int k = 0; k < 3; k++) begin
      rx_drive(32'h0000_0C40 + DW'(k), 4'h6, k == 2, 1'b1);
      mid();
      chk("rx_resume", 64'(rx_m.tvalid[0]), 64'd1);
      nxt();
    end
    rx_s.tvalid = '0;
    rx_s.tlast  = '0;
    nxt();

    // Abort in DRAIN keeps packet position
    tx_drive(1'b1, 32'h0000_00C1, 4'h7, 1'b0);
    freeze_req = 1'b1;
    nxt();
    tx_drive(1'b1, 32'h0000_00C2, 4'h8, 1'b0);
    freeze_req = 1'b0;
    mid();
    chk("abort_pass", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    freeze_req = 1'b1;
    mid();
    chk("abort_run_ready", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b1, 32'h0000_00C3, 4'h9, 1'b1);
    mid();
    chk("abort_midpkt_kept", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    mid();
    chk("abort_frozen", 64'(tx_s.tready[0]), 64'd0);
    freeze_req = 1'b0;
    nxt();
    nxt();

    // Timeout and tlast on the same cycle
    tx_drive(1'b1, 32'h0000_00D1, 4'hA, 1'b0);
    freeze_req = 1'b1;
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    repeat (TO - 1) nxt();
    tx_drive(1'b1, 32'h0000_00D2, 4'hB, 1'b1);
    mid();
    chk("simul_pass", 64'(tx_s.tready[0]), 64'd1);
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    mid();
    chk("simul_no_term", 64'(tx_m.tvalid[0]), 64'd0);
    chk("simul_frozen", 64'(tx_s.tready[0]), 64'd0);
    chk("simul_no_flag", 64'(timeout_flag), 64'd0);
    freeze_req = 1'b0;
    nxt();
    nxt();

    // Reset during TERM
    tx_drive(1'b1, 32'h0000_00E1, 4'hC, 1'b0);
    freeze_req = 1'b1;
    nxt();
    tx_drive(1'b0, '0, '0, 1'b0);
    tx_m.tready[0] = 1'b0;
    repeat (TO) nxt();
    mid();
    chk("rst_term_entered", 64'(tx_m.tvalid[0]), 64'd1);
    nxt();
    softreset  = 1'b1;
    freeze_req = 1'b0;
    nxt();
    softreset = 1'b0;
    mid();
    chk("rst_term_tvalid", 64'(tx_m.tvalid[0]), 64'd0);
    chk("rst_term_flag", 64'(timeout_flag), 64'd0);
    chk("rst_term_ack", 64'(freeze_ack), 64'd0);
    nxt();
    tx_s.tvalid[0]     = 1'b1;
    tx_s.tdata[DW-1:0] = 32'h0000_00F0;
    mid();
    chk("rst_mirror_tvalid", 64'(tx_m.tvalid[0]), 64'd1);
    chk("rst_mirror_tdata", 64'(tx_m.tdata[DW-1:0]), 64'h0000_00F0);
    chk("rst_mirror_ready", 64'(tx_s.tready[0]), 64'd0);
    nxt();
    tx_s.tvalid[0] = 1'b0;
    tx_m.tready[0] = 1'b1;
    nxt();
    mid();
    chk("tx_queue_empty", 64'(txq.size()), 64'd0);
    chk("rx_queue_empty", 64'(rxq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
